// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes eight hex nibbles (faA..faD, SA..SD) onto
// an 8-digit common-anode seven-segment display.
// - Refresh prescaler with a ghost-blanking window at the start of every slot.
// - The inputs are captured once per frame, so a frame is always coherent.
// - Optional leading-zero suppression per 4-digit group; live decimal points.
// All pins are registered and lag the internal scan state by one cycle.
module seg_scan_driver #(
  parameter int DIV   = 50000,  // clock cycles per digit slot (2..2^20)
  parameter int BLANK = 4       // all-anodes-off cycles at slot start (1..DIV-1)
) (
  input  logic        clock,
  input  logic        reset,        // asynchronous, active-low
  input  logic [15:0] fa_word,      // {faA,faB,faC,faD}
  input  logic [15:0] s_word,       // {SA,SB,SC,SD}
  input  logic        blank_lz,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  // Prescaler width: just enough to hold DIV-1.
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // ---------------------------------------------------------------------------
  // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pcnt;
  logic [2:0]    dig;
  logic [31:0]   snap;
  logic          load_pending;

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = (pcnt == PCNT_LAST);
  assign frame_wrap = slot_end && (dig == 3'd7);

  // Prescaler and digit index: pcnt walks 0..DIV-1, dig steps on each wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      dig  <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (slot_end) begin
        pcnt <= '0;
        dig  <= dig + 3'd1;
      end else begin
        pcnt <= pcnt + PCNT_ONE;
      end
    end
  end

  // Frame snapshot: captured on the first clock after reset and at each 7->0 wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: snap is a plain 32-bit register, not a memory, so it takes a real
      // async reset; the display must start from a known all-zero image.
      snap         <= '0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || frame_wrap) begin
        snap <= {fa_word, s_word};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-pin decode from the current scan state
  // ---------------------------------------------------------------------------
  logic [7:0] nib_zero;   // nibble k of snap is zero
  logic [7:0] lz_run;     // nibble k and all more-significant nibbles in its group are zero
  logic [3:0] nibble;
  logic       in_blank;
  logic       digit_blank;
  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Leading-zero runs, one per group: digits 7..4 and digits 3..0.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    nib_zero = '0;
    lz_run   = '0;
    for (int k = 0; k < 8; k++) begin
      nib_zero[k] = (snap[4*k +: 4] == 4'h0);
    end
    lz_run[7] = nib_zero[7];
    lz_run[6] = lz_run[7] & nib_zero[6];
    lz_run[5] = lz_run[6] & nib_zero[5];
    lz_run[4] = 1'b0;                     // group LSD is always shown
    lz_run[3] = nib_zero[3];
    lz_run[2] = lz_run[3] & nib_zero[2];
    lz_run[1] = lz_run[2] & nib_zero[1];
    lz_run[0] = 1'b0;                     // group LSD is always shown
  end

  // Slot phase and digit content: blank window first, then the selected digit.
  always_comb begin
    nibble      = snap[{dig, 2'b00} +: 4];
    in_blank    = (pcnt < BLANK_END);
    digit_blank = blank_lz & lz_run[dig];
    an_next     = AN_OFF;
    seg_next    = SEG_OFF;
    dp_next     = 1'b1;
    if (!in_blank) begin
      an_next  = ~(8'd1 << dig);
      seg_next = digit_blank ? SEG_OFF : hex_to_seg(nibble);
      dp_next  = ~dp_mask[dig];           // decimal point ignores zero blanking
    end
  end

  // Output registers: pins follow the decode one cycle later; frame_tick marks the wrap load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with DIV=8, BLANK=2.
// Stimulus pushes the expected content of each lit digit slot into a queue;
// a monitor pops one entry at the start of every lit slot and checks every lit
// cycle, the slot length and the blank phases. A second monitor checks the
// frame_tick period.
module tb_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int LIT   = DIV - BLANK;
  localparam int FRAME = 8 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] fa_word;
  logic [15:0] s_word;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ref_cyc = 0;
  int ticks   = 0;
  bit mon_en  = 1'b1;

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clock      (clock),
    .reset      (reset),
    .fa_word    (fa_word),
    .s_word     (s_word),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rst(input string name);
    check({name, "_an"}, {24'd0, an}, 32'hFF);
    check({name, "_seg"}, {25'd0, seg}, 32'h7F);
    check({name, "_dp"}, {31'd0, dp}, 32'd1);
    check({name, "_tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic push(input logic [7:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    sb.push_back(e);
  endtask

  // fa=1234, s=ABCD, no blanking, no decimal points; digit 0 first.
  task automatic push_frame_a();
    push(8'hFE, 7'b0100001, 1'b1);  // d
    push(8'hFD, 7'b1000110, 1'b1);  // C
    push(8'hFB, 7'b0000011, 1'b1);  // b
    push(8'hF7, 7'b0001000, 1'b1);  // A
    push(8'hEF, 7'b0011001, 1'b1);  // 4
    push(8'hDF, 7'b0110000, 1'b1);  // 3
    push(8'hBF, 7'b0100100, 1'b1);  // 2
    push(8'h7F, 7'b1111001, 1'b1);  // 1
  endtask

  // fa=0040, s=0000, blank_lz=1, dp_mask=10.
  task automatic push_frame_lz();
    push(8'hFE, 7'b1000000, 1'b1);  // 0, group LSD kept
    push(8'hFD, 7'b1111111, 1'b1);  // blanked
    push(8'hFB, 7'b1111111, 1'b1);  // blanked
    push(8'hF7, 7'b1111111, 1'b1);  // blanked
    push(8'hEF, 7'b1000000, 1'b0);  // 0, group LSD kept, dp lit
    push(8'hDF, 7'b0011001, 1'b1);  // 4
    push(8'hBF, 7'b1111111, 1'b1);  // blanked
    push(8'h7F, 7'b1111111, 1'b1);  // blanked
  endtask

  // Waits (at falling edges) for a fresh slot with the given anode pattern.
  task automatic wait_slot(input logic [7:0] a);
    int n;
    n = 0;
    while (an == a && n < 2000) begin
      @(negedge clock);
      n++;
    end
    while (an != a && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("wait_slot_timeout", {31'd0, n < 2000}, 32'd1);
  endtask

  // Counts clock edges from reset release until the first anode is driven.
  task automatic measure_latency();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (an == 8'hFF && n < 100);
    check("first_lit_latency", n, BLANK + 1);
  endtask

  // Slot monitor: one queue entry per lit slot, blank cycles must be dark.
  exp_t cur;
  bit   in_slot  = 1'b0;
  int   slot_len = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (an != 8'hFF) begin
        if (!in_slot) begin
          in_slot  = 1'b1;
          slot_len = 0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            cur = '0;
            $display("FAIL slot_unexpected an=%h seg=%h dp=%b at t=%0t", an, seg, dp, $time);
          end else begin
            cur = sb.pop_front();
          end
        end
        slot_len++;
        check("slot_content", {16'd0, an, seg, dp}, {16'd0, cur});
      end else begin
        if (in_slot) begin
          if (reset) check("slot_length", slot_len, LIT);
          in_slot = 1'b0;
        end
        check("blank_seg", {25'd0, seg}, 32'h7F);
        check("blank_dp", {31'd0, dp}, 32'd1);
      end
    end
  end

  // Frame monitor: ticks come exactly one frame after release and after each other.
  always @(negedge clock) begin
    if (reset && frame_tick) begin
      check("frame_period", cyc - ref_cyc, FRAME);
      ref_cyc = cyc;
      ticks++;
    end
  end

  initial begin
    int n;
    fa_word  = 16'h5A5A;
    s_word   = 16'hC3C3;
    blank_lz = 1'b1;
    dp_mask  = 8'hFF;

    // Reset held for three clocks, checked before the first edge too.
    #1 reset = 1'b0;
    #1 check_rst("pre_edge");
    repeat (3) begin
      @(negedge clock);
      check_rst("in_reset");
    end

    fa_word  = 16'h1234;
    s_word   = 16'hABCD;
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    push_frame_a();
    push_frame_a();
    // Third frame: fa changed mid frame two; cut short by reset in digit 5.
    push(8'hFE, 7'b0100001, 1'b1);
    push(8'hFD, 7'b1000110, 1'b1);
    push(8'hFB, 7'b0000011, 1'b1);
    push(8'hF7, 7'b0001000, 1'b1);
    push(8'hEF, 7'b0001110, 1'b1);  // F
    push(8'hDF, 7'b0001110, 1'b1);  // F

    #1 reset = 1'b1;
    ref_cyc = cyc;
    measure_latency();

    // Change fa during frame two's digit 2: invisible until frame three.
    wait_slot(8'hFB);
    wait_slot(8'hFB);
    fa_word = 16'hFFFF;

    // Async reset in the ON phase of frame three's digit 5.
    wait_slot(8'hDF);
    wait_slot(8'hDF);
    #1 reset = 1'b0;
    #1 check_rst("async_reset");
    fa_word  = 16'h0040;
    s_word   = 16'h0000;
    blank_lz = 1'b1;
    dp_mask  = 8'h10;
    push_frame_lz();
    push_frame_lz();
    @(negedge clock);
    check_rst("held_reset");
    #1 reset = 1'b1;
    ref_cyc = cyc;
    measure_latency();

    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", sb.size(), 0);
    n = 0;
    while (an != 8'hFF && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("last_slot_end", {24'd0, an}, 32'hFF);
    #1 mon_en = 1'b0;
    check("tick_count", ticks, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
